// File: rtl/ring_counter_gen.sv
// Parametrised one-hot / Johnson ring counter used as a phase generator.
// Supports direction, parallel load, illegal-state repair, wrap pulse and position.
module ring_counter_gen #(
  parameter int W = 4,
  parameter bit AUTO_FIX = 1'b1,
  localparam int PW = $clog2(2*W)
) (
  input  logic          clk,
  input  logic          clr_n,
  input  logic          en,
  input  logic          dir,
  input  logic          mode,
  input  logic          load,
  input  logic [W-1:0]  load_val,
  output logic [W-1:0]  q,
  output logic [PW-1:0] pos,
  output logic          wrap,
  output logic          illegal
);

  logic [W-1:0]  q_q, q_d;
  logic          wrap_q, wrap_d;
  logic          mode_q, mode_d;
  logic [W-1:0]  shifted;
  logic          fb;
  logic          ring_ok, john_ok;
  logic [PW-1:0] ring_pos, john_pos;
  logic [W-1:0]  all1;
  int            ones;

  function automatic logic [W-1:0] seed(input logic m);
    return m ? '0 : {1'b1, {(W-1){1'b0}}};
  endfunction

  // Classify q against both legal pattern families and find its position.
  always_comb begin
    all1     = '1;
    ones     = 0;
    ring_pos = '0;
    john_ok  = 1'b0;
    john_pos = '0;
    for (int i = 0; i < W; i++) begin
      if (q_q[i]) begin
        ones     = ones + 1;
        ring_pos = PW'(W - 1 - i);
      end
    end
    ring_ok = (ones == 1);
    for (int k = 0; k <= W; k++) begin
      if (q_q == ~(all1 >> k)) begin
        john_ok  = 1'b1;
        john_pos = PW'(k);
      end
    end
    for (int k = 1; k < W; k++) begin
      if (q_q == (all1 >> (W - k))) begin
        john_ok  = 1'b1;
        john_pos = PW'(2*W - k);
      end
    end
  end

  assign illegal = mode_q ? !john_ok : !ring_ok;
  assign pos     = illegal ? '0 : (mode_q ? john_pos : ring_pos);

  always_comb begin
    if (!dir) begin
      fb      = mode_q ? ~q_q[0] : q_q[0];
      shifted = {fb, q_q[W-1:1]};
    end else begin
      fb      = mode_q ? ~q_q[W-1] : q_q[W-1];
      shifted = {q_q[W-2:0], fb};
    end
  end

  always_comb begin
    q_d    = q_q;
    wrap_d = 1'b0;
    mode_d = mode_q;
    if (load) begin
      q_d = load_val;
    end else if (mode != mode_q) begin
      q_d    = seed(mode);
      mode_d = mode;
    end else if (AUTO_FIX && illegal) begin
      q_d = seed(mode_q);
    end else if (en) begin
      q_d    = shifted;
      wrap_d = (shifted == seed(mode_q));
    end
  end

  always_ff @(posedge clk) begin
    if (!clr_n) begin
      q_q    <= seed(mode);
      wrap_q <= 1'b0;
      mode_q <= mode;
    end else begin
      q_q    <= q_d;
      wrap_q <= wrap_d;
      mode_q <= mode_d;
    end
  end

  assign q    = q_q;
  assign wrap = wrap_q;

endmodule

// File: tb/tb_ring_counter_gen.sv
// Bench for ring_counter_gen: directed plan steps then random traffic,
// both against a position-based reference model (AUTO_FIX on and off).
module tb_ring_counter_gen;

  localparam int W  = 4;
  localparam int PW = $clog2(2*W);

  logic          clk = 1'b0;
  logic          clr_n, en, dir, mode, load;
  logic [W-1:0]  load_val;
  logic [W-1:0]  q1, q0;
  logic [PW-1:0] p1, p0;
  logic          w1, w0, i1, i0;

  logic [W-1:0]  mq1, mq0;
  logic          mm1, mm0, mw1, mw0;
  int            checks = 0;
  int            errors = 0;

  always #5 clk = ~clk;

  ring_counter_gen #(.W(W), .AUTO_FIX(1'b1)) u_fix (
    .clk(clk), .clr_n(clr_n), .en(en), .dir(dir), .mode(mode),
    .load(load), .load_val(load_val),
    .q(q1), .pos(p1), .wrap(w1), .illegal(i1)
  );

  ring_counter_gen #(.W(W), .AUTO_FIX(1'b0)) u_nofix (
    .clk(clk), .clr_n(clr_n), .en(en), .dir(dir), .mode(mode),
    .load(load), .load_val(load_val),
    .q(q0), .pos(p0), .wrap(w0), .illegal(i0)
  );

  // Legal pattern at phase p: ring = single bit walking down from MSB,
  // Johnson = ones filling from the top, then draining from the top.
  function automatic logic [W-1:0] pat(input logic m, input int p);
    int v;
    if (!m)          v = 1 << (W - 1 - p);
    else if (p <= W) v = (1 << W) - (1 << (W - p));
    else             v = (1 << (2*W - p)) - 1;
    return v[W-1:0];
  endfunction

  function automatic int period(input logic m);
    return m ? 2*W : W;
  endfunction

  function automatic int posof(input logic m, input logic [W-1:0] v);
    for (int p = 0; p < period(m); p++)
      if (pat(m, p) == v) return p;
    return -1;
  endfunction

  function automatic logic [W-1:0] shbits(input logic m, input logic d,
                                          input logic [W-1:0] v);
    logic b;
    if (!d) begin
      b = m ? ~v[0] : v[0];
      return (v >> 1) | (W'(b) << (W - 1));
    end
    b = m ? ~v[W-1] : v[W-1];
    return (v << 1) | W'(b);
  endfunction

  task automatic mstep(input bit fix, inout logic [W-1:0] mq,
                       inout logic mm, inout logic mw);
    int p;
    mw = 1'b0;
    if (!clr_n) begin
      mq = pat(mode, 0);
      mm = mode;
    end else if (load) begin
      mq = load_val;
    end else if (mode != mm) begin
      mq = pat(mode, 0);
      mm = mode;
    end else if (fix && posof(mm, mq) < 0) begin
      mq = pat(mm, 0);
    end else if (en) begin
      p = posof(mm, mq);
      if (p >= 0)
        mq = pat(mm, (p + (dir ? period(mm) - 1 : 1)) % period(mm));
      else
        mq = shbits(mm, dir, mq);
      mw = (mq == pat(mm, 0));
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int epos(input logic m, input logic [W-1:0] v);
    return posof(m, v) < 0 ? 0 : posof(m, v);
  endfunction

  task automatic cyc();
    @(posedge clk);
    mstep(1'b1, mq1, mm1, mw1);
    mstep(1'b0, mq0, mm0, mw0);
    #1;
    chk("q_fix",    32'(q1), 32'(mq1));
    chk("wrap_fix", 32'(w1), 32'(mw1));
    chk("pos_fix",  32'(p1), 32'(epos(mm1, mq1)));
    chk("ill_fix",  32'(i1), 32'(posof(mm1, mq1) < 0));
    chk("q_nofix",    32'(q0), 32'(mq0));
    chk("wrap_nofix", 32'(w0), 32'(mw0));
    chk("pos_nofix",  32'(p0), 32'(epos(mm0, mq0)));
    chk("ill_nofix",  32'(i0), 32'(posof(mm0, mq0) < 0));
  endtask

  initial begin
    clr_n = 1'b0; en = 1'b0; dir = 1'b0; mode = 1'b0;
    load = 1'b0; load_val = '0;
    cyc();
    chk("rst_q", 32'(q1), 32'h8);
    chk("rst_wrap", 32'(w1), 32'h0);

    clr_n = 1'b1; en = 1'b1;
    repeat (3) cyc();
    chk("ring_q3", 32'(q1), 32'h1);
    chk("ring_nowrap", 32'(w1), 32'h0);
    cyc();
    chk("ring_wrap", 32'(w1), 32'h1);

    mode = 1'b1;
    cyc();
    repeat (8) cyc();
    chk("john_wrap_q", 32'(q1), 32'h0);
    chk("john_wrap", 32'(w1), 32'h1);
    dir = 1'b1;
    cyc();
    chk("john_up_q", 32'(q1), 32'h1);
    repeat (7) cyc();
    dir = 1'b0;

    mode = 1'b0;
    cyc();
    load = 1'b1; load_val = 4'b0110;
    cyc();
    chk("ld_ill", 32'(i1), 32'h1);
    chk("ld_pos", 32'(p1), 32'h0);
    load = 1'b0;
    cyc();
    chk("fix_q", 32'(q1), 32'h8);
    chk("nofix_q1", 32'(q0), 32'h3);
    cyc();
    chk("nofix_q2", 32'(q0), 32'h9);

    load = 1'b1; load_val = 4'b0010;
    cyc();
    load = 1'b0; mode = 1'b1;
    cyc();
    chk("mchg_q", 32'(q1), 32'h0);
    chk("mchg_wrap", 32'(w1), 32'h0);
    cyc();
    chk("mchg_next", 32'(q1), 32'h8);

    mode = 1'b0;
    cyc();
    load = 1'b1; load_val = 4'b0001;
    cyc();
    clr_n = 1'b0; load_val = 4'b0110;
    cyc();
    chk("clr_q", 32'(q1), 32'h8);
    clr_n = 1'b1; load = 1'b0; en = 1'b0;
    repeat (3) cyc();
    chk("hold_q", 32'(q1), 32'h8);

    load = 1'b1; load_val = 4'b0101; mode = 1'b1;
    cyc();
    chk("ldm_q", 32'(q1), 32'h5);
    load = 1'b0;
    cyc();
    chk("ldm_seed", 32'(q1), 32'h0);

    for (int n = 0; n < 600; n++) begin
      clr_n    = ($urandom_range(0, 39) != 0);
      load     = ($urandom_range(0, 9) == 0);
      load_val = W'($urandom);
      en       = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 15) == 0) mode = ~mode;
      if ($urandom_range(0, 7) == 0)  dir  = ~dir;
      cyc();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ring_counter_gen.md
Name: ring_counter_gen

Overview:
- Parametrised successor to the team's fixed 4-bit ring counter.
- Shifts a one-hot ring pattern or a Johnson (twisted-ring) pattern of configurable width.
- Supports runtime direction and mode selection, parallel load, illegal-state self-correction, wrap pulse and binary position output.
- Sits in the timing/sequencing layer as a phase generator for strobes and multiplexed displays.

Parameters:
- W, 4, counter width in bits; legal range 2..32.
- AUTO_FIX, 1, 1 = illegal state is replaced by the seed on the next clock edge; 0 = illegal pattern keeps shifting.
- PW, clog2(2*W), width of pos output; derived, must not be overridden.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- clr_n  in  1  synchronous active-low reset; sampled on rising edge of clk only.
- en  in  1  shift enable.
- dir  in  1  0 = bits move toward LSB (q[i-1]<=q[i]); 1 = bits move toward MSB.
- mode  in  1  0 = ring (one-hot), 1 = Johnson.
- load  in  1  parallel-load strobe.
- load_val  in  W  value loaded when load=1.
- q  out  W  counter state (registered).
- pos  out  PW  binary position of q (combinational from q).
- wrap  out  1  registered one-cycle pulse.
- illegal  out  1  combinational; q is not a legal pattern for the current mode.

Behaviour:
- Seed: ring = 1 followed by W-1 zeros (MSB set); Johnson = all zeros.
- Reset (clr_n=0 at edge): q <= seed(mode), wrap <= 0, internal mode_q <= mode. Reset mid-shift or mid-load overrides everything.
- Priority at each edge, highest first: reset > load > mode change > fix > shift > hold.
- load=1: q <= load_val unchecked, regardless of en; wrap <= 0.
- Mode change (mode != mode_q): q <= seed(mode), mode_q <= mode, wrap <= 0; no shift that cycle.
- Fix: AUTO_FIX=1 and illegal=1 gives q <= seed(mode_q), wrap <= 0.
- Shift (en=1), dir=0: q[i-1] <= q[i]; q[W-1] <= q[0] (ring) or ~q[0] (Johnson).
- Shift (en=1), dir=1: q[i+1] <= q[i]; q[0] <= q[W-1] (ring) or ~q[W-1] (Johnson).
- Hold: en=0 keeps q unchanged.
- wrap <= 1 only when a shift (not load, fix or reset) produces q == seed(mode_q); otherwise 0. Latency: wrap is high in the same cycle q shows the seed.
- Ring legal: exactly one bit set. pos = index from MSB: MSB set gives 0, LSB set gives W-1. Period W.
- Johnson legal: 1..10..0 form (k leading ones, k=0..W) or 0..01..1 form (k trailing ones, k=1..W-1). pos = k for the leading-ones form; 2W-k for the trailing-ones form. Period 2W; all-ones is pos W.
- illegal=1 forces pos=0.
- dir change takes effect on the next enabled edge with no glitch; pos simply counts backward.
- en=0 with illegal state and AUTO_FIX=1: fix still occurs, since fix does not require en.
- W=2 Johnson: sequence 00,10,11,01.

Test Plan (W=4, AUTO_FIX=1 unless noted):
1. clr_n=0 one edge, mode=0 -> q=1000, pos=0, wrap=0. Then en=1, dir=0 for 4 edges -> q=0100,0010,0001,1000; wrap=1 only at the last edge; pos=1,2,3,0.
2. mode=1 with 8 enabled edges, dir=0 -> q=1000,1100,1110,1111,0111,0011,0001,0000; pos=1..7,0; wrap on 0000. Repeat with dir=1 -> q=0001,0011,0111,1111,1110,1100,1000,0000.
3. load=1, load_val=0110, mode=0 -> q=0110, illegal=1, pos=0; next edge -> q=1000, wrap=0, illegal=0. With AUTO_FIX=0, same load and en=1 -> q=0011, then 1001.
4. Counting in ring mode at q=0010, toggle mode to 1 with en=1 -> q=0000 next edge, no shift, wrap=0; the following edge gives q=1000.
5. clr_n=0 asserted in the same cycle as load=1 and en=1 with q=0001 -> q=1000, wrap=0. en=0 for 3 edges -> q holds, wrap stays 0.
6. Simultaneous load=1 and mode change -> q=load_val; mode change applied on the next edge (q <= seed).
